sha1_multiblock_hash: RTL and testbench

- Full SHA-1 engine. Reads a message of arbitrary byte length from the dpsram over port A.
- Applies FIPS 180 padding in hardware, hashes all 512-bit blocks at one round per cycle, and optionally writes the 160-bit digest back to the dpsram.
- Successor to the single-block SHA-1 core. Adds multi-block support, padding, endianness selection, digest write-back and a proper done handshake.

---
 rtl/sha1_multiblock_hash.sv | 244 ++++++++++++++++++++++++
 tb/tb_sha1_multiblock_hash.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sha1_multiblock_hash.sv
// SHA-1 engine: fetches a byte-length message over port A, applies FIPS 180 padding on the
// fly, hashes each 512-bit block at one round per cycle and optionally writes the digest back.
module sha1_multiblock_hash #(
  parameter int unsigned ADDR_W            = 16,
  parameter bit          MEM_LITTLE_ENDIAN = 1'b1,
  parameter bit          WRITE_DIGEST      = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_hash,
  input  logic [31:0]       message_addr,
  input  logic [31:0]       message_size,
  input  logic [31:0]       output_addr,
  output logic [159:0]      hash,
  output logic              done,
  output logic              port_A_clk,
  output logic [ADDR_W-1:0] port_A_addr,
  output logic [31:0]       port_A_data_in,
  input  logic [31:0]       port_A_data_out,
  output logic              port_A_we
);

  localparam logic [31:0] IV0 = 32'h67452301;
  localparam logic [31:0] IV1 = 32'hEFCDAB89;
  localparam logic [31:0] IV2 = 32'h98BADCFE;
  localparam logic [31:0] IV3 = 32'h10325476;
  localparam logic [31:0] IV4 = 32'hC3D2E1F0;

  typedef enum logic [2:0] {
    StIdle, StLoad, StCompute, StUpdate, StWrite, StDone
  } state_e;

  function automatic logic [31:0] mem_order(input logic [31:0] x);
    return MEM_LITTLE_ENDIAN ? {x[7:0], x[15:8], x[23:16], x[31:24]} : x;
  endfunction

  state_e      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [31:0] blk_q, blk_d;
  logic        done_q, done_d;

  logic [31:0] msg_addr_q, size_q, out_addr_q, nblocks_q;
  logic [31:0] h_q [5];
  logic [31:0] a_q, b_q, c_q, d_q, e_q;
  logic [31:0] w_q [16];

  logic        start_ok, last_blk, rd_en;
  logic [31:0] nwords, rd_word_idx, cap_word_idx, cap_base, byte_idx;
  logic [31:0] rd_word, cap_word;
  logic [3:0]  cap_idx, t4, i3, i8, i14;
  logic [31:0] w_mix, w_new, wt, f, k, temp, wr_word, addr_full;
  logic        unused_addr;

  assign start_ok     = start_hash && (state_q == StIdle || state_q == StDone);
  assign last_blk     = (blk_q == nblocks_q - 32'd1);
  assign nwords       = (size_q + 32'd3) >> 2;
  assign rd_word_idx  = (blk_q << 4) + {28'd0, cnt_q[3:0]};
  assign rd_en        = (state_q == StLoad) && (cnt_q < 7'd16) && (rd_word_idx < nwords);
  // Word captured this cycle was addressed in the previous LOAD cycle.
  assign cap_idx      = cnt_q[3:0] - 4'd1;
  assign cap_word_idx = (blk_q << 4) + {28'd0, cap_idx};
  assign rd_word      = mem_order(port_A_data_out);

  assign hash        = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4]};
  assign done        = done_q;
  assign port_A_clk  = clk;
  assign port_A_addr = addr_full[ADDR_W-1:0];
  assign unused_addr = ^addr_full;

  // Padding: mask bytes past the end, insert the 0x80 marker and the bit length.
  always_comb begin
    cap_base = cap_word_idx << 2;
    byte_idx = 32'd0;
    cap_word = 32'd0;
    for (int n = 0; n < 4; n++) begin
      byte_idx = cap_base + 32'(n);
      if (byte_idx < size_q) begin
        cap_word[31-8*n -: 8] = rd_word[31-8*n -: 8];
      end else if (byte_idx == size_q) begin
        cap_word[31-8*n -: 8] = 8'h80;
      end
    end
    if (last_blk && cap_idx == 4'd14) cap_word = {29'd0, size_q[31:29]};
    if (last_blk && cap_idx == 4'd15) cap_word = {size_q[28:0], 3'b000};
  end

  // Message schedule and round function for round t = cnt_q.
  always_comb begin
    t4    = cnt_q[3:0];
    i3    = t4 + 4'd13;
    i8    = t4 + 4'd8;
    i14   = t4 + 4'd2;
    w_mix = w_q[i3] ^ w_q[i8] ^ w_q[i14] ^ w_q[t4];
    w_new = {w_mix[30:0], w_mix[31]};
    wt    = (cnt_q < 7'd16) ? w_q[t4] : w_new;
    if (cnt_q < 7'd20) begin
      f = (b_q & c_q) | (~b_q & d_q);
      k = 32'h5A827999;
    end else if (cnt_q < 7'd40) begin
      f = b_q ^ c_q ^ d_q;
      k = 32'h6ED9EBA1;
    end else if (cnt_q < 7'd60) begin
      f = (b_q & c_q) | (b_q & d_q) | (c_q & d_q);
      k = 32'h8F1BBCDC;
    end else begin
      f = b_q ^ c_q ^ d_q;
      k = 32'hCA62C1D6;
    end
    temp = {a_q[26:0], a_q[31:27]} + f + e_q + k + wt;
  end

  // Port A drive: pipelined reads in LOAD, digest write-back in WRITE, idle otherwise.
  always_comb begin
    addr_full      = 32'd0;
    port_A_we      = 1'b0;
    port_A_data_in = 32'd0;
    case (cnt_q[2:0])
      3'd0:    wr_word = h_q[0];
      3'd1:    wr_word = h_q[1];
      3'd2:    wr_word = h_q[2];
      3'd3:    wr_word = h_q[3];
      default: wr_word = h_q[4];
    endcase
    if (rd_en) begin
      addr_full = msg_addr_q + (rd_word_idx << 2);
    end else if (state_q == StWrite) begin
      port_A_we      = 1'b1;
      addr_full      = out_addr_q + {27'd0, cnt_q[2:0], 2'b00};
      port_A_data_in = mem_order(wr_word);
    end
  end

  // FSM next-state, phase counter, block index and done flag.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 7'd1;
    blk_d   = blk_q;
    done_d  = done_q;
    unique case (state_q)
      StIdle, StDone: begin
        cnt_d = 7'd0;
        if (start_ok) begin
          state_d = StLoad;
          blk_d   = 32'd0;
          done_d  = 1'b0;
        end else if (state_q == StDone) begin
          done_d = 1'b1;
        end
      end
      StLoad: begin
        if (cnt_q == 7'd16) begin
          state_d = StCompute;
          cnt_d   = 7'd0;
        end
      end
      StCompute: begin
        if (cnt_q == 7'd79) begin
          state_d = StUpdate;
          cnt_d   = 7'd0;
        end
      end
      StUpdate: begin
        cnt_d = 7'd0;
        if (!last_blk) begin
          state_d = StLoad;
          blk_d   = blk_q + 32'd1;
        end else if (WRITE_DIGEST) begin
          state_d = StWrite;
        end else begin
          state_d = StDone;
        end
      end
      StWrite: begin
        if (cnt_q == 7'd4) begin
          state_d = StDone;
          cnt_d   = 7'd0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 7'd0;
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 7'd0;
      blk_q   <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      done_q  <= done_d;
    end
  end

  // Datapath: request latch, schedule buffer, working variables and chaining value.
  always_ff @(posedge clk) begin
    if (reset) begin
      msg_addr_q <= 32'd0;
      size_q     <= 32'd0;
      out_addr_q <= 32'd0;
      nblocks_q  <= 32'd0;
      h_q[0] <= IV0; h_q[1] <= IV1; h_q[2] <= IV2; h_q[3] <= IV3; h_q[4] <= IV4;
      a_q <= 32'd0; b_q <= 32'd0; c_q <= 32'd0; d_q <= 32'd0; e_q <= 32'd0;
      for (int n = 0; n < 16; n++) w_q[n] <= 32'd0;
    end else begin
      if (start_ok) begin
        msg_addr_q <= message_addr;
        size_q     <= message_size;
        out_addr_q <= output_addr;
        nblocks_q  <= ((message_size + 32'd8) >> 6) + 32'd1;
        h_q[0] <= IV0; h_q[1] <= IV1; h_q[2] <= IV2; h_q[3] <= IV3; h_q[4] <= IV4;
      end
      case (state_q)
        StLoad: begin
          if (cnt_q != 7'd0) w_q[cap_idx] <= cap_word;
          a_q <= h_q[0]; b_q <= h_q[1]; c_q <= h_q[2]; d_q <= h_q[3]; e_q <= h_q[4];
        end
        StCompute: begin
          if (cnt_q >= 7'd16) w_q[t4] <= w_new;
          e_q <= d_q;
          d_q <= c_q;
          c_q <= {b_q[1:0], b_q[31:2]};
          b_q <= a_q;
          a_q <= temp;
        end
        StUpdate: begin
          h_q[0] <= h_q[0] + a_q;
          h_q[1] <= h_q[1] + b_q;
          h_q[2] <= h_q[2] + c_q;
          h_q[3] <= h_q[3] + d_q;
          h_q[4] <= h_q[4] + e_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_multiblock_hash.sv
// Scoreboard bench for sha1_multiblock_hash: a write-back build and a no-write-back build
// share one dpsram model; a negedge monitor checks digests, done latency and memory writes.
module tb_sha1_multiblock_hash;

  localparam logic [159:0] IV      = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
  localparam logic [159:0] H_ABC   = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam logic [159:0] H_EMPTY = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
  localparam logic [159:0] H_56    = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

  typedef struct {
    logic [159:0] h;
    int           lat;
    int           start_edge;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic         clk = 1'b0;
  logic         reset, start, start2;
  logic [31:0]  msg_addr, msg_size, out_addr;
  logic [159:0] hash1, hash2;
  logic         done1, done2, pclk1, pclk2, we1, we2;
  logic [15:0]  addr1, addr2;
  logic [31:0]  din1, din2, dout1, dout2;
  logic [31:0]  mem [4096];

  int   total = 0, bad = 0, cyc = 0;
  int   ndone1 = 0, ndone2 = 0, reads_seen = 0;
  bit   watch = 1'b0;
  logic prev1 = 1'b0, prev2 = 1'b0;
  exp_t q1[$], q2[$];
  wr_t  wq[$];

  always #5 clk = ~clk;

  sha1_multiblock_hash #(.ADDR_W(16), .MEM_LITTLE_ENDIAN(1'b1), .WRITE_DIGEST(1'b1)) dut (
    .clk(clk), .reset(reset), .start_hash(start), .message_addr(msg_addr),
    .message_size(msg_size), .output_addr(out_addr), .hash(hash1), .done(done1),
    .port_A_clk(pclk1), .port_A_addr(addr1), .port_A_data_in(din1),
    .port_A_data_out(dout1), .port_A_we(we1)
  );

  sha1_multiblock_hash #(.ADDR_W(16), .MEM_LITTLE_ENDIAN(1'b1), .WRITE_DIGEST(1'b0)) dut_nw (
    .clk(clk), .reset(reset), .start_hash(start2), .message_addr(msg_addr),
    .message_size(msg_size), .output_addr(out_addr), .hash(hash2), .done(done2),
    .port_A_clk(pclk2), .port_A_addr(addr2), .port_A_data_in(din2),
    .port_A_data_out(dout2), .port_A_we(we2)
  );

  // Synchronous-read dpsram model; digest writes are checked, not stored.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    dout1 <= mem[addr1[13:2]];
    dout2 <= mem[addr2[13:2]];
  end

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUTs present a result or a write.
  always @(negedge clk) begin
    exp_t e;
    wr_t  w;
    if (done1 && !prev1) begin
      ndone1++;
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: got done=1 expected no completion");
      end else begin
        e = q1.pop_front();
        chk("digest", hash1, e.h);
        chk("latency", 160'(cyc - e.start_edge), 160'(e.lat));
      end
    end
    if (done2 && !prev2) begin
      ndone2++;
      if (q2.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done_nw: got done=1 expected no completion");
      end else begin
        e = q2.pop_front();
        chk("digest_nw", hash2, e.h);
        chk("latency_nw", 160'(cyc - e.start_edge), 160'(e.lat));
      end
    end
    if (we1) begin
      if (wq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", addr1, din1);
      end else begin
        w = wq.pop_front();
        chk("wr_addr", 160'(addr1), 160'(w.addr[15:0]));
        chk("wr_data", 160'(din1), 160'(w.data));
      end
    end
    if (we2) begin
      total++; bad++;
      $display("FAIL nw_write: got we=1 expected we=0");
    end
    if (watch && addr1 >= 16'h0200 && addr1 < 16'h0240) reads_seen++;
    prev1 <= done1;
    prev2 <= done2;
  end

  // Issue one hash request, queue its expectations and wait (bounded) for completion.
  task automatic run(input logic [31:0] ma, input logic [31:0] ms, input logic [31:0] oa,
                     input logic [159:0] eh, input int lat, input bit use2, input int pulse_at);
    int   n1, n2;
    bit   ok;
    exp_t e;
    wr_t  w;
    n1 = ndone1;
    n2 = ndone2;
    ok = 1'b0;
    @(posedge clk); #1;
    msg_addr = ma; msg_size = ms; out_addr = oa;
    start = 1'b1; start2 = use2;
    e.h = eh; e.lat = lat; e.start_edge = cyc + 1;
    q1.push_back(e);
    if (use2) begin
      e.lat = lat - 5;
      q2.push_back(e);
    end
    for (int j = 0; j < 5; j++) begin
      w.addr = oa + 32'(4 * j);
      w.data = bswap(eh[159-32*j -: 32]);
      wq.push_back(w);
    end
    for (int i = 1; i <= 400 && !ok; i++) begin
      @(posedge clk); #1;
      start = 1'b0; start2 = 1'b0;
      if (i == pulse_at) begin
        msg_addr = 32'h200; msg_size = 32'd0; out_addr = 32'hA00; start = 1'b1;
      end
      if (ndone1 > n1 && (!use2 || ndone2 > n2)) ok = 1'b1;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL timeout: got no done within 400 cycles expected done");
    end
  endtask

  initial begin
    string s;
    s = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[64] = 32'h00636261;                              // "abc" at 0x100
    for (int i = 128; i < 144; i++) mem[i] = 32'hFFFFFFFF;  // 0x200 region
    for (int i = 0; i < 56; i++) mem[192 + i / 4][8 * (i % 4) +: 8] = s[i];  // 0x300
    mem[256] = 32'hAB636261;                             // "abc" with garbage at 0x400
    mem[257] = 32'hDEADBEEF;

    reset = 1'b1; start = 1'b0; start2 = 1'b0;
    msg_addr = 32'd0; msg_size = 32'd0; out_addr = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", 160'(done1), 160'(0));
    chk("rst_iv", hash1, IV);
    chk("rst_we", 160'(we1), 160'(0));
    chk("rst_addr", 160'(addr1), 160'(0));
    chk("rst_din", 160'(din1), 160'(0));
    chk("rst_iv_nw", hash2, IV);
    chk("port_A_clk", 160'(pclk1), 160'(clk));
    reset = 1'b0;

    // "abc" on both builds
    run(32'h100, 32'd3, 32'h800, H_ABC, 104, 1'b1, 0);

    // empty message over a region of all-ones
    watch = 1'b1;
    run(32'h200, 32'd0, 32'h840, H_EMPTY, 104, 1'b0, 0);
    watch = 1'b0;
    chk("no_reads", 160'(reads_seen), 160'(0));

    // 56-byte message: two blocks
    run(32'h300, 32'd56, 32'h880, H_56, 202, 1'b0, 0);

    // garbage byte beyond the message end must be masked
    run(32'h400, 32'd3, 32'h8C0, H_ABC, 104, 1'b0, 0);

    // reset mid-COMPUTE aborts; nothing expected from the aborted run
    @(posedge clk); #1;
    msg_addr = 32'h100; msg_size = 32'd3; out_addr = 32'h900; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_done", 160'(done1), 160'(0));
    chk("abort_iv", hash1, IV);
    chk("abort_we", 160'(we1), 160'(0));
    reset = 1'b0;
    run(32'h100, 32'd3, 32'h900, H_ABC, 104, 1'b0, 0);

    // second start mid-COMPUTE is ignored
    run(32'h100, 32'd3, 32'h940, H_ABC, 104, 1'b0, 50);

    repeat (10) @(posedge clk);
    chk("q_digest_empty", 160'(q1.size()), 160'(0));
    chk("q_digest_nw_empty", 160'(q2.size()), 160'(0));
    chk("q_write_empty", 160'(wq.size()), 160'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
